hdlc_rx_destuff: RTL and testbench
==================================

HDLC_RX_DESTUFF -- requirements
Module: hdlc_rx_destuff

Interface
REQ-001 SHALL have parameter MIN_FRAME_BITS, default 32, the minimum number of destuffed bits between flags for a valid frame.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the destuffed-bit counter.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BitEn  input  1  raw line bit strobe, one cycle per received bit; back-to-back strobes allowed.
REQ-006 SHALL have port RxD  input  1  raw serial bit, sampled when BitEn=1.
REQ-007 SHALL have port SData  output  1  destuffed data bit for the downstream RX shift stage.
REQ-008 SHALL have port En  output  1  one-cycle strobe qualifying SData.
REQ-009 SHALL have port Clr  output  1  one-cycle pulse on every detected flag or abort, realigning the downstream shift stage.
REQ-010 SHALL have port FrameStart  output  1  one-cycle pulse with the first En of a frame.
REQ-011 SHALL have port FrameEnd  output  1  one-cycle pulse on the closing flag of a valid frame.
REQ-012 SHALL have port FrameErr  output  1  one-cycle pulse on the closing flag of a short or non-octet frame.
REQ-013 SHALL have port Abort  output  1  one-cycle pulse on an abort sequence.
REQ-014 SHALL have port InFrame  output  1  high while in state DATA.

Function
REQ-015 SHALL keep an 8-bit raw history window, shifted on each BitEn, plus an 8-entry delay line of {bit, valid}.
REQ-016 SHALL keep a consecutive-ones counter, incremented on raw 1 and saturating at 7, and cleared on raw 0.
REQ-017 SHALL mark a raw 0 as invalid (stuffed) in the delay line when it arrives with ones count exactly 5.
REQ-018 SHALL detect a flag when the window equals 0111_1110 after a shift; it SHALL then clear all 8 delay-line valid bits in that cycle and pulse Clr one cycle later.
REQ-019 SHALL retain the history on a flag so that shared-zero flags (011111101111110) are both detected.
REQ-020 SHALL, on each BitEn, present the entry leaving the delay line on SData with En=1 the next cycle if that entry is valid and the state is SYNC or DATA; latency is exactly 8 BitEn strobes plus 1 clock.
REQ-021 SHALL implement states HUNT, SYNC and DATA: HUNT->SYNC on flag; SYNC->DATA on the first En (pulse FrameStart); SYNC->SYNC on repeated flags with no output; DATA->SYNC on flag.
REQ-022 SHALL count emitted bits in DATA with a CNT_W counter that saturates at all-ones and clears on entry to SYNC.
REQ-023 SHALL, on DATA->SYNC, pulse FrameEnd if count >= MIN_FRAME_BITS and count mod 8 = 0, and otherwise pulse FrameErr; never both.
REQ-024 SHALL treat ones count reaching 7 as an abort: go to HUNT from any state, clear delay-line valids, pulse Clr, emit no further En until the next flag.
REQ-025 SHALL give a flag and an abort priority over data emission in the same BitEn cycle.
REQ-026 SHALL hold all outputs at 0 when BitEn=0 (pulses only), with state retained.

Reset
REQ-027 SHALL, on Rstn=0, asynchronously set the state to HUNT and clear the history, delay line, ones counter and bit counter, and drive every output to 0.
REQ-028 SHALL, on reset mid-frame, emit no FrameEnd/FrameErr; after release it SHALL require a new flag before any En.

Configuration
REQ-029 SHALL compile in the abort detection of REQ-024 and the Abort port pulse when macro HDLC_RX_ABORT_EN is defined.
REQ-030 SHALL, without HDLC_RX_ABORT_EN, tie Abort to 0, apply no special action at seven ones, and let the frame continue until the next flag.

Structure
REQ-031 SHALL take the state encoding, flag pattern 8'h7E, stuff threshold 5 and abort threshold 7 from the shared hdlc_pkg definitions.
REQ-032 SHALL place the 8-entry {bit, valid} delay line with bulk invalidate in sub-module hdlc_rx_delay_line.

Verification
REQ-033 SHALL cover: flag, 32 data bits 0xA5 x4 unstuffed, flag -> 32 En strobes with LSB-first A5 pattern, then FrameStart, FrameEnd, and two Clr.
REQ-034 SHALL cover: data byte 0xFF (stuffed on line as 111110111) -> a 0 dropped, exactly 8 En strobes for that byte, all SData=1.
REQ-035 SHALL cover: flag, 12 data bits, flag -> FrameErr=1, FrameEnd=0.
REQ-036 SHALL cover: flag, 16 bits, then eight 1s -> Abort (macro defined), state HUNT, no FrameEnd; the next flag re-enters SYNC.
REQ-037 SHALL cover: shared-zero flags 011111101111110 -> two Clr pulses, no En; Rstn low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared HDLC receive definitions: hunt/sync/data state encoding, the flag
// octet, the ones-run thresholds for bit stuffing and abort, and the depth
// of the destuffing delay line.
package hdlc_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } hdlc_state_e;

  localparam logic [7:0] HDLC_FLAG       = 8'h7E;
  localparam logic [2:0] HDLC_STUFF_ONES = 3'd5;
  localparam logic [2:0] HDLC_ABORT_ONES = 3'd7;
  localparam int         HDLC_DLY_DEPTH  = 8;

endpackage

// File: rtl/hdlc_rx_delay_line.sv
// Eight-entry {bit, valid} delay line for the HDLC receive destuffer.
// A new entry is shifted in on each Shift; Inval clears every valid bit
// (including the entry arriving in the same cycle). TailBit/TailVld show
// the oldest entry as it will look after this cycle's update, so the caller
// can emit it in the same strobe that would otherwise kill it.
module hdlc_rx_delay_line
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rstn,
  input  logic Shift,
  input  logic DIn,
  input  logic VIn,
  input  logic Inval,
  output logic TailBit,
  output logic TailVld
);

  logic [HDLC_DLY_DEPTH-1:0] bit_p0;
  logic [HDLC_DLY_DEPTH-1:0] vld_p0;
  logic [HDLC_DLY_DEPTH-1:0] bit_p1;
  logic [HDLC_DLY_DEPTH-1:0] vld_p1;

  // Next contents: optional shift, then bulk invalidate on flag/abort.
  always_comb begin
    bit_p0 = bit_p1;
    vld_p0 = vld_p1;
    if (Shift) begin
      bit_p0 = {bit_p1[HDLC_DLY_DEPTH-2:0], DIn};
      vld_p0 = {vld_p1[HDLC_DLY_DEPTH-2:0], VIn};
    end
    if (Inval) begin
      vld_p0 = '0;
    end
  end

  // ---- stage boundary: delay line storage ----
  // Line registers, cleared asynchronously so a reset forgets any queued bits.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      bit_p1 <= '0;
      vld_p1 <= '0;
    end else begin
      bit_p1 <= bit_p0;
      vld_p1 <= vld_p0;
    end
  end

  assign TailBit = bit_p0[HDLC_DLY_DEPTH-1];
  assign TailVld = vld_p0[HDLC_DLY_DEPTH-1];

endmodule

// File: rtl/hdlc_rx_destuff.sv
// HDLC receive flag detector and bit destuffer.
// Watches the raw bit stream, removes stuffed zeros, detects flags (and,
// with HDLC_RX_ABORT_EN defined, abort sequences of seven ones), and hands
// destuffed bits to the downstream shift stage with frame boundary pulses.
// Every bit passes through an 8-deep delay line so that the flag octet can
// be discarded once it is recognised; a bit accepted on strobe n is
// presented the clock after strobe n+7 (the eighth strobe counting its own).
module hdlc_rx_destuff
  import hdlc_pkg::*;
#(
  parameter int MIN_FRAME_BITS = 32,
  parameter int CNT_W          = 16
) (
  input  logic Clk,
  input  logic Rstn,
  input  logic BitEn,
  input  logic RxD,
  output logic SData,
  output logic En,
  output logic Clr,
  output logic FrameStart,
  output logic FrameEnd,
  output logic FrameErr,
  output logic Abort,
  output logic InFrame
);

  // Ones-run counter step: count up on a one, saturate at seven, reset on zero.
  function automatic logic [2:0] ones_inc(input logic [2:0] ones, input logic b);
    if (!b) begin
      return 3'd0;
    end else if (ones == 3'd7) begin
      return 3'd7;
    end else begin
      return ones + 3'd1;
    end
  endfunction

  // Destuffed-bit counter step, saturating at all-ones.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  // A frame closes cleanly only if it is long enough and a whole number of octets.
  function automatic logic frame_ok(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(MIN_FRAME_BITS)) && (c[2:0] == 3'd0);
  endfunction

  hdlc_state_e      state_p1;
  logic [7:0]       hist_p0;
  logic [7:0]       hist_p1;
  logic [2:0]       ones_p0;
  logic [2:0]       ones_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             stuffed_p0;
  logic             flag_p0;
  logic             abort_p0;
  logic             inval_p0;
  logic             emit_p0;
  logic             tail_bit_p0;
  logic             tail_vld_p0;

  logic             sdata_p1;
  logic             en_p1;
  logic             clr_p1;
  logic             fstart_p1;
  logic             fend_p1;
  logic             ferr_p1;
`ifdef HDLC_RX_ABORT_EN
  logic             abort_p1;
`endif

  // ---- stage 0: raw bit classification ----
  // Window and ones-run as they will be after this strobe (held when idle).
  always_comb begin
    hist_p0 = hist_p1;
    ones_p0 = ones_p1;
    if (BitEn) begin
      hist_p0 = {hist_p1[6:0], RxD};
      ones_p0 = ones_inc(ones_p1, RxD);
    end
  end

  // A zero following exactly five ones was inserted by the transmitter.
  assign stuffed_p0 = ~RxD & (ones_p1 == HDLC_STUFF_ONES);
  assign flag_p0    = BitEn & (hist_p0 == HDLC_FLAG);

`ifdef HDLC_RX_ABORT_EN
  // Fire once, on the strobe where the run first reaches seven ones.
  assign abort_p0 = BitEn & RxD & (ones_p0 == HDLC_ABORT_ONES) &
                    (ones_p1 != HDLC_ABORT_ONES);
`else
  assign abort_p0 = 1'b0;
`endif

  assign inval_p0 = flag_p0 | abort_p0;

  hdlc_rx_delay_line u_delay_line (
    .Clk     (Clk),
    .Rstn    (Rstn),
    .Shift   (BitEn),
    .DIn     (RxD),
    .VIn     (~stuffed_p0),
    .Inval   (inval_p0),
    .TailBit (tail_bit_p0),
    .TailVld (tail_vld_p0)
  );

  // Flag and abort both invalidate the line, so they always beat emission.
  assign emit_p0 = BitEn & tail_vld_p0 & ~inval_p0 & (state_p1 != ST_HUNT);

  // ---- stage 1: framing state machine and registered outputs ----
  // Tracks hunt/sync/data, counts frame bits and produces one-cycle pulses.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_p1  <= ST_HUNT;
      hist_p1   <= '0;
      ones_p1   <= '0;
      cnt_p1    <= '0;
      sdata_p1  <= 1'b0;
      en_p1     <= 1'b0;
      clr_p1    <= 1'b0;
      fstart_p1 <= 1'b0;
      fend_p1   <= 1'b0;
      ferr_p1   <= 1'b0;
`ifdef HDLC_RX_ABORT_EN
      abort_p1  <= 1'b0;
`endif
    end else begin
      hist_p1   <= hist_p0;
      ones_p1   <= ones_p0;
      sdata_p1  <= 1'b0;
      en_p1     <= 1'b0;
      clr_p1    <= 1'b0;
      fstart_p1 <= 1'b0;
      fend_p1   <= 1'b0;
      ferr_p1   <= 1'b0;
`ifdef HDLC_RX_ABORT_EN
      abort_p1  <= 1'b0;
`endif
      if (abort_p0) begin
        // Abort drops the frame silently; a new flag is needed to resync.
        state_p1 <= ST_HUNT;
        clr_p1   <= 1'b1;
`ifdef HDLC_RX_ABORT_EN
        abort_p1 <= 1'b1;
`endif
      end else if (flag_p0) begin
        clr_p1   <= 1'b1;
        cnt_p1   <= '0;
        state_p1 <= ST_SYNC;
        if (state_p1 == ST_DATA) begin
          if (frame_ok(cnt_p1)) begin
            fend_p1 <= 1'b1;
          end else begin
            ferr_p1 <= 1'b1;
          end
        end
      end else if (emit_p0) begin
        en_p1    <= 1'b1;
        sdata_p1 <= tail_bit_p0;
        if (state_p1 == ST_SYNC) begin
          state_p1  <= ST_DATA;
          fstart_p1 <= 1'b1;
          cnt_p1    <= CNT_W'(1);
        end else begin
          cnt_p1 <= cnt_inc(cnt_p1);
        end
      end
    end
  end

  assign SData      = sdata_p1;
  assign En         = en_p1;
  assign Clr        = clr_p1;
  assign FrameStart = fstart_p1;
  assign FrameEnd   = fend_p1;
  assign FrameErr   = ferr_p1;
  assign InFrame    = (state_p1 == ST_DATA);
`ifdef HDLC_RX_ABORT_EN
  assign Abort      = abort_p1;
`else
  assign Abort      = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_destuff.sv
// Directed bench for hdlc_rx_destuff: frames with and without stuffing,
// short/non-octet frames, abort (expectations follow HDLC_RX_ABORT_EN),
// shared-zero flags and reset in mid-frame.
module tb_hdlc_rx_destuff;

  logic Clk = 1'b0;
  logic Rstn;
  logic BitEn;
  logic RxD;
  logic SData, En, Clr, FrameStart, FrameEnd, FrameErr, Abort, InFrame;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  hdlc_rx_destuff #(.MIN_FRAME_BITS(32), .CNT_W(16)) dut (
    .Clk        (Clk),
    .Rstn       (Rstn),
    .BitEn      (BitEn),
    .RxD        (RxD),
    .SData      (SData),
    .En         (En),
    .Clr        (Clr),
    .FrameStart (FrameStart),
    .FrameEnd   (FrameEnd),
    .FrameErr   (FrameErr),
    .Abort      (Abort),
    .InFrame    (InFrame)
  );

  // Output monitor: event counters and a log of every destuffed bit.
  int   en_cnt = 0, clr_cnt = 0, fs_cnt = 0, fe_cnt = 0, ferr_cnt = 0, ab_cnt = 0;
  int   quiet_viol = 0, both_viol = 0;
  logic sbits [0:4095];
  logic be_q = 1'b0;

  always @(posedge Clk) be_q <= BitEn;

  always @(negedge Clk) begin
    if (En) begin
      sbits[en_cnt % 4096] = SData;
      en_cnt++;
    end
    if (Clr)        clr_cnt++;
    if (FrameStart) fs_cnt++;
    if (FrameEnd)   fe_cnt++;
    if (FrameErr)   ferr_cnt++;
    if (Abort)      ab_cnt++;
    if (!be_q && (SData | En | Clr | FrameStart | FrameEnd | FrameErr | Abort)) quiet_viol++;
    if (FrameEnd && FrameErr) both_viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_bits(input int base, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = sbits[(base + i) % 4096];
    return r;
  endfunction

  function automatic logic [63:0] mask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Snapshot of monitor counters taken at the start of each case.
  int s_en, s_clr, s_fs, s_fe, s_ferr, s_ab;
  task automatic snap();
    s_en = en_cnt; s_clr = clr_cnt; s_fs = fs_cnt;
    s_fe = fe_cnt; s_ferr = ferr_cnt; s_ab = ab_cnt;
  endtask

  int gap = 0;
  int tb_ones = 0;

  task automatic send_bit(input logic b);
    BitEn = 1'b1;
    RxD   = b;
    @(posedge Clk);
    #1;
    BitEn = 1'b0;
    RxD   = 1'b0;
    repeat (gap) @(posedge Clk);
    if (gap > 0) #1;
  endtask

  // Data bit with transmitter-side zero insertion after five ones.
  task automatic send_data(input logic b);
    send_bit(b);
    if (b) begin
      tb_ones++;
      if (tb_ones == 5) begin
        send_bit(1'b0);
        tb_ones = 0;
      end
    end else begin
      tb_ones = 0;
    end
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) send_data(d[i]);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data(d[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 7; i >= 0; i--) send_bit(f[i]);
    tb_ones = 0;
  endtask

  task automatic settle();
    repeat (2) @(posedge Clk);
    #1;
  endtask

  localparam logic [63:0] PAT = 64'hC3E1_9D2B_64F0_5A17;
  int lens [4]    = '{12, 24, 36, 40};
  int len_ok [4]  = '{0, 0, 0, 1};
  int mid_en;

  initial begin
    Rstn  = 1'b0;
    BitEn = 1'b0;
    RxD   = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_outs", {SData, En, Clr, FrameStart, FrameEnd, FrameErr, Abort, InFrame}, 8'h00);
    Rstn = 1'b1;
    @(posedge Clk);
    #1;

    // Flag, 0xA5 x4, flag, with an idle cycle between strobes.
    gap = 1;
    snap();
    send_flag();
    send_byte(8'hA5);
    send_byte(8'hA5);
    check("a5_inframe_mid", InFrame, 1);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_flag();
    settle();
    check("a5_en",     en_cnt - s_en, 32);
    check("a5_bits",   get_bits(s_en, 32), 64'hA5A5_A5A5);
    check("a5_fstart", fs_cnt - s_fs, 1);
    check("a5_fend",   fe_cnt - s_fe, 1);
    check("a5_ferr",   ferr_cnt - s_ferr, 0);
    check("a5_clr",    clr_cnt - s_clr, 2);
    check("a5_inframe_end", InFrame, 0);

    // 0xFF goes out as 111110111; the inserted zero must vanish.
    gap = 0;
    snap();
    send_flag();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_flag();
    settle();
    check("ff_en",   en_cnt - s_en, 32);
    check("ff_bits", get_bits(s_en, 32), 64'h00FF_00FF);
    check("ff_fend", fe_cnt - s_fe, 1);

    // Length boundaries: short, short octet, non-octet, good.
    gap = 2;
    for (int k = 0; k < 4; k++) begin
      snap();
      send_flag();
      send_bits(PAT, lens[k]);
      send_flag();
      settle();
      check($sformatf("len%0d_en", lens[k]),   en_cnt - s_en, lens[k]);
      check($sformatf("len%0d_bits", lens[k]), get_bits(s_en, lens[k]), PAT & mask(lens[k]));
      check($sformatf("len%0d_fend", lens[k]), fe_cnt - s_fe, len_ok[k]);
      check($sformatf("len%0d_ferr", lens[k]), ferr_cnt - s_ferr, 1 - len_ok[k]);
    end

    // Flag, 16 bits, then eight raw ones.
    gap = 0;
    snap();
    send_flag();
    send_byte(8'h5A);
    send_byte(8'h5A);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    settle();
    mid_en = en_cnt;
`ifdef HDLC_RX_ABORT_EN
    check("abort_pulse",   ab_cnt - s_ab, 1);
    check("abort_inframe", InFrame, 0);
    // Bit 15 would leave on the strobe carrying the seventh one, where abort wins.
    check("abort_en_before", en_cnt - s_en, 15);
`endif
    send_flag();
    settle();
`ifdef HDLC_RX_ABORT_EN
    check("abort_en_after", en_cnt - mid_en, 0);
    check("abort_no_close", (fe_cnt - s_fe) + (ferr_cnt - s_ferr), 0);
`else
    check("noabort_pulse", ab_cnt - s_ab, 0);
    check("noabort_en",    en_cnt - s_en, 24);
    check("noabort_ferr",  ferr_cnt - s_ferr, 1);
    check("noabort_fend",  fe_cnt - s_fe, 0);
`endif
    snap();
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_flag();
    settle();
    check("resync_fstart", fs_cnt - s_fs, 1);
    check("resync_fend",   fe_cnt - s_fe, 1);

    // Shared-zero flags: two flags, nothing emitted.
    snap();
    begin
      logic [14:0] sz;
      sz = 15'b011111101111110;
      for (int i = 14; i >= 0; i--) send_bit(sz[i]);
    end
    settle();
    check("shared_clr", clr_cnt - s_clr, 2);
    check("shared_en",  en_cnt - s_en, 0);

    // Reset in mid-frame while bits are streaming out.
    send_flag();
    send_bits(PAT, 20);
    check("prereset_en", En, 1);
    Rstn = 1'b0;
    #1;
    check("midreset_outs", {SData, En, Clr, FrameStart, FrameEnd, FrameErr, Abort, InFrame}, 8'h00);
    @(posedge Clk);
    #1;
    Rstn = 1'b1;
    snap();
    send_bits(PAT, 16);
    settle();
    check("postreset_no_en",    en_cnt - s_en, 0);
    check("postreset_no_close", (fe_cnt - s_fe) + (ferr_cnt - s_ferr), 0);
    snap();
    send_flag();
    send_byte(8'h3C);
    send_flag();
    settle();
    check("postreset_en",   en_cnt - s_en, 8);
    check("postreset_bits", get_bits(s_en, 8), 64'h3C);
    check("postreset_ferr", ferr_cnt - s_ferr, 1);

    check("idle_quiet",     quiet_viol, 0);
    check("fend_ferr_excl", both_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
